// File: rtl/legv8_pipe_core.sv
// Five-stage LEGv8 subset pipeline (IF/ID/EX/MEM/WB) with EX-stage forwarding,
// load-use stall and predict-not-taken branches resolved in EX.
module legv8_pipe_core #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] instruction,
    input  logic [63:0] mem_read_data,
    output logic [63:0] PC,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        control_memwrite,
    output logic        control_memread
);
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_ORR = 2'd3;

    typedef struct packed {
        logic        vld;
        logic [63:0] pc;
        logic [31:0] instr;
    } ifid_t;

    // rm carries Rm for R-type and Rt for STUR/CBZ, so one forwarding path serves all
    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        is_cbz;
        logic        is_b;
        logic        use_imm;
        logic [1:0]  aluop;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rn_val;
        logic [63:0] rm_val;
    } idex_t;

    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] store;
    } exmem_t;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rd;
        logic [63:0] data;
    } memwb_t;

    function automatic logic [63:0] rf_read(input logic [4:0] r, input logic [63:0] stored,
                                            input memwb_t wb);
        logic [63:0] v;
        v = stored;
        if (wb.regwrite && wb.rd == r) v = wb.data;
        if (r == 5'd31) v = '0;
        return v;
    endfunction

    function automatic logic [63:0] fwd(input logic [4:0] r, input logic [63:0] id_val,
                                        input exmem_t mem, input memwb_t wb);
        logic [63:0] v;
        v = id_val;
        if (wb.regwrite && wb.rd != 5'd31 && wb.rd == r) v = wb.data;
        if (mem.regwrite && mem.rd != 5'd31 && mem.rd == r) v = mem.alu;
        return v;
    endfunction

    logic [63:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [63:0] regs_q [0:31];
    logic [63:0] regs_d [0:31];

    idex_t       id_dec;
    logic [10:0] op11;
    logic        id_uses_rn, id_uses_rm, load_use;
    logic [63:0] ex_a, ex_b, ex_opb, ex_alu, ex_target;
    logic        ex_taken;

    // ---- ID: decode, register read with write-back bypass, hazard detect
    always_comb begin
        id_dec     = '0;
        id_uses_rn = 1'b0;
        id_uses_rm = 1'b0;
        op11       = ifid_q.instr[31:21];
        id_dec.pc  = ifid_q.pc;
        id_dec.rn  = ifid_q.instr[9:5];
        id_dec.rm  = ifid_q.instr[4:0];
        id_dec.rd  = ifid_q.instr[4:0];
        if (ifid_q.vld) begin
            if (op11 == 11'h458 || op11 == 11'h658 || op11 == 11'h450 || op11 == 11'h550) begin
                id_dec.regwrite = 1'b1;
                id_dec.rm       = ifid_q.instr[20:16];
                id_uses_rn      = 1'b1;
                id_uses_rm      = 1'b1;
                case (op11)
                    11'h658: id_dec.aluop = ALU_SUB;
                    11'h450: id_dec.aluop = ALU_AND;
                    11'h550: id_dec.aluop = ALU_ORR;
                    default: id_dec.aluop = ALU_ADD;
                endcase
            end else if (ifid_q.instr[31:22] == 10'h244) begin
                id_dec.regwrite = 1'b1;
                id_dec.use_imm  = 1'b1;
                id_dec.imm      = {52'd0, ifid_q.instr[21:10]};
                id_uses_rn      = 1'b1;
            end else if (op11 == 11'h7C2 || op11 == 11'h7C0) begin
                id_dec.regwrite = (op11 == 11'h7C2);
                id_dec.memread  = (op11 == 11'h7C2);
                id_dec.memwrite = (op11 == 11'h7C0);
                id_dec.use_imm  = 1'b1;
                id_dec.imm      = {{55{ifid_q.instr[20]}}, ifid_q.instr[20:12]};
                id_uses_rn      = 1'b1;
                id_uses_rm      = (op11 == 11'h7C0);
            end else if (ifid_q.instr[31:24] == 8'hB4) begin
                id_dec.is_cbz = 1'b1;
                id_dec.imm    = {{43{ifid_q.instr[23]}}, ifid_q.instr[23:5], 2'b00};
                id_uses_rm    = 1'b1;
            end else if (ifid_q.instr[31:26] == 6'h05) begin
                id_dec.is_b = 1'b1;
                id_dec.imm  = {{36{ifid_q.instr[25]}}, ifid_q.instr[25:0], 2'b00};
            end
        end
        id_dec.rn_val = rf_read(id_dec.rn, regs_q[id_dec.rn], memwb_q);
        id_dec.rm_val = rf_read(id_dec.rm, regs_q[id_dec.rm], memwb_q);
        load_use = idex_q.memread &&
                   ((id_uses_rn && idex_q.rd == id_dec.rn) ||
                    (id_uses_rm && idex_q.rd == id_dec.rm));
    end

    // ---- EX: forwarded operands, ALU, branch resolution
    always_comb begin
        ex_a   = fwd(idex_q.rn, idex_q.rn_val, exmem_q, memwb_q);
        ex_b   = fwd(idex_q.rm, idex_q.rm_val, exmem_q, memwb_q);
        ex_opb = idex_q.use_imm ? idex_q.imm : ex_b;
        case (idex_q.aluop)
            ALU_SUB: ex_alu = ex_a - ex_opb;
            ALU_AND: ex_alu = ex_a & ex_opb;
            ALU_ORR: ex_alu = ex_a | ex_opb;
            default: ex_alu = ex_a + ex_opb;
        endcase
        ex_taken  = idex_q.is_b || (idex_q.is_cbz && ex_b == 64'd0);
        ex_target = idex_q.pc + idex_q.imm;
    end

    // ---- Next state for every stage; a taken branch overrides a load-use stall
    always_comb begin
        pc_d         = pc_q + 64'd4;
        ifid_d.vld   = 1'b1;
        ifid_d.pc    = pc_q;
        ifid_d.instr = instruction;
        idex_d       = id_dec;
        if (ex_taken) begin
            pc_d   = ex_target;
            ifid_d = '0;
            idex_d = '0;
        end else if (load_use) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.rd       = idex_q.rd;
        exmem_d.alu      = ex_alu;
        exmem_d.store    = ex_b;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.rd       = exmem_q.rd;
        memwb_d.data     = exmem_q.memread ? mem_read_data : exmem_q.alu;
        for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
        if (memwb_q.regwrite && memwb_q.rd != 5'd31) regs_d[memwb_q.rd] = memwb_q.data;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign PC               = pc_q;
    assign mem_address      = exmem_q.alu;
    assign mem_write_data   = exmem_q.store;
    assign control_memwrite = exmem_q.memwrite;
    assign control_memread  = exmem_q.memread;
endmodule

// File: tb/tb_legv8_pipe_core.sv
// Bench for legv8_pipe_core: an instruction-level interpreter predicts every data
// memory access; a monitor compares each strobe against that expected stream.
module tb_legv8_pipe_core;
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] instruction;
    logic [63:0] mem_read_data;
    logic [63:0] PC;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        control_memwrite;
    logic        control_memread;

    legv8_pipe_core #(.RESET_PC(64'h0)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .instruction(instruction),
        .mem_read_data(mem_read_data), .PC(PC), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .control_memwrite(control_memwrite),
        .control_memread(control_memread)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
    } txn_t;

    logic [31:0] imem [256];
    logic [63:0] dmem [128];
    logic [63:0] dmem_init [128];
    logic [63:0] pc_tr [512];
    txn_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    assign instruction   = (PC < 64'd1024) ? imem[PC[9:2]] : 32'h0;
    assign mem_read_data = dmem[mem_address[9:3]];

    always @(posedge CLOCK) begin
        if (RESET !== 1'b1) begin
            for (int i = 0; i < 128; i++) dmem[i] <= dmem_init[i];
        end else if (control_memwrite === 1'b1) begin
            dmem[mem_address[9:3]] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every memory strobe must match the next predicted access
    always @(negedge CLOCK) begin
        txn_t t;
        if (RESET === 1'b1 && (control_memwrite === 1'b1 || control_memread === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_access: wr=%0b addr=%h, expected no access",
                         control_memwrite, mem_address);
            end else begin
                t = exp_q.pop_front();
                check("access_is_store", {63'd0, control_memwrite}, {63'd0, t.wr});
                check("access_addr", mem_address, t.addr);
                if (t.wr) check("store_data", mem_write_data, t.data);
                else      check("load_data", mem_read_data, t.data);
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn,
                                             input logic [11:0] imm);
        return {10'h244, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_mem(input logic [10:0] op, input logic [8:0] imm,
                                            input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cbz(input logic [18:0] imm, input logic [4:0] rt);
        return {8'hB4, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'h05, imm};
    endfunction

    task automatic clear_imem();
        foreach (imem[i]) imem[i] = 32'h0;
    endtask

    task automatic add_dump(input int start);
        for (int i = 0; i < 32; i++) imem[start + i] = enc_mem(11'h7C0, 9'(8 * i), 5'd31, 5'(i));
    endtask

    // Architectural interpreter: executes the program one instruction at a time
    task automatic model_run(input int len);
        logic [63:0] x [32];
        logic [63:0] m [128];
        logic [63:0] pc, nxt, a, b, t, addr, wv;
        logic signed [63:0] off;
        logic [31:0] ins;
        logic        wen;
        int          steps;
        exp_q.delete();
        foreach (x[i]) x[i] = '0;
        foreach (m[i]) m[i] = dmem_init[i];
        pc = '0;
        steps = 0;
        while (pc < 64'(len * 4) && steps < 400) begin
            steps++;
            ins = (pc < 64'd1024) ? imem[pc[9:2]] : 32'h0;
            a   = (ins[9:5] == 5'd31) ? 64'd0 : x[ins[9:5]];
            b   = (ins[20:16] == 5'd31) ? 64'd0 : x[ins[20:16]];
            t   = (ins[4:0] == 5'd31) ? 64'd0 : x[ins[4:0]];
            nxt = pc + 64'd4;
            wen = 1'b0;
            wv  = '0;
            if (ins[31:21] == 11'h458) begin wen = 1'b1; wv = a + b; end
            else if (ins[31:21] == 11'h658) begin wen = 1'b1; wv = a - b; end
            else if (ins[31:21] == 11'h450) begin wen = 1'b1; wv = a & b; end
            else if (ins[31:21] == 11'h550) begin wen = 1'b1; wv = a | b; end
            else if (ins[31:22] == 10'h244) begin wen = 1'b1; wv = a + 64'(ins[21:10]); end
            else if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) begin
                off  = $signed(ins[20:12]);
                addr = a + 64'(off);
                if (ins[31:21] == 11'h7C2) begin
                    wen = 1'b1;
                    wv  = m[addr[9:3]];
                    exp_q.push_back('{1'b0, addr, wv});
                end else begin
                    m[addr[9:3]] = t;
                    exp_q.push_back('{1'b1, addr, t});
                end
            end else if (ins[31:24] == 8'hB4) begin
                off = $signed(ins[23:5]);
                if (t == 64'd0) nxt = pc + 64'(off * 4);
            end else if (ins[31:26] == 6'h05) begin
                off = $signed(ins[25:0]);
                nxt = pc + 64'(off * 4);
            end
            if (wen && ins[4:0] != 5'd31) x[ins[4:0]] = wv;
            pc = nxt;
        end
    endtask

    task automatic run_prog(input int len, input int cycles);
        model_run(len);
        RESET = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        check("reset_pc", PC, 64'd0);
        check("reset_memwrite", {63'd0, control_memwrite}, 64'd0);
        check("reset_memread", {63'd0, control_memread}, 64'd0);
        check("reset_mem_address", mem_address, 64'd0);
        check("reset_mem_write_data", mem_write_data, 64'd0);
        RESET = 1'b1;
        pc_tr[0] = PC;
        for (int c = 1; c < cycles; c++) begin
            @(posedge CLOCK);
            #1;
            pc_tr[c] = PC;
        end
        check("pending_accesses", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [4:0] pick_dst();
        int v;
        v = int'($urandom_range(0, 8));
        return (v == 8) ? 5'd31 : 5'(v);
    endfunction
    function automatic logic [4:0] pick_src();
        int v;
        v = int'($urandom_range(0, 9));
        return (v == 8) ? 5'd28 : (v == 9) ? 5'd31 : 5'(v);
    endfunction
    function automatic logic [8:0] rand_off9();
        int o;
        o = 8 * (int'($urandom_range(0, 63)) - 32);
        return 9'(o);
    endfunction

    task automatic gen_random(output int len);
        int idx, kind, mx;
        logic [4:0] d, s, s2;
        clear_imem();
        foreach (dmem_init[i]) dmem_init[i] = {$urandom, $urandom};
        imem[0] = enc_addi(5'd28, 5'd31, 12'd512);
        idx = 1;
        while (idx < 41) begin
            kind = int'($urandom_range(0, 9));
            d  = pick_dst();
            s  = pick_src();
            s2 = pick_src();
            mx = (41 - idx < 4) ? 41 - idx : 4;
            case (kind)
                0: imem[idx] = enc_r(11'h458, s2, s, d);
                1: imem[idx] = enc_r(11'h658, s2, s, d);
                2: imem[idx] = enc_r(11'h450, s2, s, d);
                3: imem[idx] = enc_r(11'h550, s2, s, d);
                4: imem[idx] = enc_addi(d, s, 12'($urandom_range(0, 4095)));
                5, 6: imem[idx] = enc_mem(11'h7C2, rand_off9(), 5'd28, d);
                7: imem[idx] = enc_mem(11'h7C0, rand_off9(), 5'd28, s);
                8: imem[idx] = enc_cbz(19'($urandom_range(1, mx)), s);
                default: imem[idx] = enc_b(26'($urandom_range(1, mx)));
            endcase
            idx++;
        end
        add_dump(idx);
        len = idx + 32;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bexp [7];
        int len;
        RESET = 1'b0;
        foreach (dmem_init[i]) dmem_init[i] = 64'(i) * 64'h0101;

        // Forwarding chain plus XZR write/read, no stalls expected
        clear_imem();
        imem[0] = enc_addi(5'd1, 5'd31, 12'd5);
        imem[1] = enc_addi(5'd2, 5'd31, 12'd7);
        imem[2] = enc_r(11'h458, 5'd2, 5'd1, 5'd3);
        imem[3] = enc_r(11'h658, 5'd1, 5'd3, 5'd4);
        imem[4] = enc_addi(5'd31, 5'd31, 12'd9);
        imem[5] = enc_r(11'h458, 5'd31, 5'd31, 5'd9);
        add_dump(6);
        run_prog(38, 140);
        for (int c = 0; c < 8; c++) check("pc_sequential", pc_tr[c], 64'(4 * c));

        // Store, load, dependent use: one stall
        clear_imem();
        imem[0] = enc_addi(5'd1, 5'd31, 12'd40);
        imem[1] = enc_mem(11'h7C0, 9'd8, 5'd31, 5'd1);
        imem[2] = enc_mem(11'h7C2, 9'd8, 5'd31, 5'd2);
        imem[3] = enc_r(11'h458, 5'd2, 5'd2, 5'd5);
        add_dump(4);
        run_prog(36, 140);
        for (int c = 0; c < 9; c++)
            check("pc_load_use", pc_tr[c], (c <= 4) ? 64'(4 * c) : 64'(4 * (c - 1)));

        // CBZ taken over two wrong-path writes, then CBZ not taken
        clear_imem();
        imem[0] = enc_cbz(19'd3, 5'd0);
        imem[1] = enc_addi(5'd6, 5'd31, 12'd1);
        imem[2] = enc_addi(5'd7, 5'd31, 12'd2);
        imem[3] = enc_addi(5'd1, 5'd31, 12'd5);
        imem[4] = enc_cbz(19'd3, 5'd1);
        imem[5] = enc_addi(5'd3, 5'd31, 12'd3);
        add_dump(6);
        run_prog(38, 140);

        // Unconditional backward branch forming a loop
        clear_imem();
        imem[8] = enc_b(26'h3FFFFFE);
        bexp = '{64'h20, 64'h24, 64'h28, 64'h18, 64'h1C, 64'h20, 64'h24};
        run_prog(9, 20);
        for (int c = 0; c < 7; c++) check("pc_branch_b", pc_tr[c + 8], bexp[c]);

        for (int p = 0; p < 6; p++) begin
            gen_random(len);
            run_prog(len, 320);
        end

        // Reset while a store sits in EX: the store must never reach memory
        clear_imem();
        exp_q.delete();
        imem[0] = enc_addi(5'd1, 5'd31, 12'd40);
        imem[1] = enc_mem(11'h7C0, 9'd8, 5'd31, 5'd1);
        RESET = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;
        check("midreset_memwrite", {63'd0, control_memwrite}, 64'd0);
        check("midreset_pc", PC, 64'd0);
        check("midreset_mem_address", mem_address, 64'd0);
        clear_imem();
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        repeat (10) @(posedge CLOCK);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
